seq_partial_product_multiplier: RTL and testbench

//   Parametrised unsigned multiplier, iterative over partial-product columns.

---
 rtl/seq_partial_product_multiplier.sv | 113 +++++++++++
 tb/tb_seq_partial_product_multiplier.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_partial_product_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_partial_product_multiplier: iterative unsigned multiplier that adds    |
// | BITS_PER_CYC shifted partial products of a per cycle into a 2*WIDTH acc.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module seq_partial_product_multiplier #(
    parameter int WIDTH        = 8,
    parameter int BITS_PER_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int N     = WIDTH / BITS_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   p_r;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   pp [BITS_PER_CYC];

    // a_sh already carries the column weight cnt*BITS_PER_CYC; only the
    // intra-cycle offset i is applied here.
    for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_pp
        assign pp[i] = b_r[i] ? (a_sh << i) : '0;
    end

    always_comb begin
        acc_sum = acc;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            acc_sum = acc_sum + pp[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)        state_nxt = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (out_ready)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            p_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= {{WIDTH{1'b0}}, a};
                        b_r  <= b;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    acc  <= acc_sum;
                    a_sh <= a_sh << BITS_PER_CYC;
                    b_r  <= b_r >> BITS_PER_CYC;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        p_r <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All outputs decode registered state only; no input-to-output paths.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign p         = p_r;

endmodule
`default_nettype wire

// File: tb/tb_seq_partial_product_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_partial_product_multiplier: scoreboard bench over four configs.     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_seq_partial_product_multiplier;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] p;
        int          acc;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- DUT 0: WIDTH=8, BPC=1 ----------------
    logic        iv8 = 0, or8 = 1;
    logic        ir8, ov8, busy8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8, e8 = 0;
    exp_t        q8[$];
    int          nacc8 = 0;
    logic        pv8 = 0;

    seq_partial_product_multiplier #(.WIDTH(8), .BITS_PER_CYC(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8));

    // ---------------- DUT 1: WIDTH=8, BPC=2 ----------------
    logic        iv8b = 0, or8b = 1;
    logic        ir8b, ov8b, busy8b;
    logic [7:0]  a8b = 0, b8b = 0;
    logic [15:0] p8b, e8b = 0;
    exp_t        q8b[$];
    int          nacc8b = 0;
    logic        pv8b = 0;

    seq_partial_product_multiplier #(.WIDTH(8), .BITS_PER_CYC(2)) u8b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8b), .in_ready(ir8b), .a(a8b), .b(b8b),
        .out_valid(ov8b), .out_ready(or8b), .p(p8b), .busy(busy8b));

    // ---------------- DUT 2: WIDTH=2, BPC=2 ----------------
    logic        iv2 = 0, or2 = 1;
    logic        ir2, ov2, busy2;
    logic [1:0]  a2 = 0, b2 = 0;
    logic [3:0]  p2, e2 = 0;
    exp_t        q2[$];
    int          nacc2 = 0;
    int          last2 = -1;
    logic        pv2 = 0;

    seq_partial_product_multiplier #(.WIDTH(2), .BITS_PER_CYC(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .p(p2), .busy(busy2));

    // ---------------- DUT 3: WIDTH=16, BPC=4 ----------------
    logic        iv16 = 0, or16 = 1;
    logic        ir16, ov16, busy16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16, e16 = 0;
    exp_t        q16[$];
    int          nacc16 = 0;
    logic        pv16 = 0;
    logic        rnd16 = 0;

    seq_partial_product_multiplier #(.WIDTH(16), .BITS_PER_CYC(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .p(p16), .busy(busy16));

    // Input side: push the expected product when a handshake is about to occur.
    always @(negedge clk) begin
        if (iv8 && ir8) begin
            q8.push_back('{p: 32'(e8), acc: cyc + 1});
            nacc8 <= nacc8 + 1;
        end
        if (iv8b && ir8b) begin
            q8b.push_back('{p: 32'(e8b), acc: cyc + 1});
            nacc8b <= nacc8b + 1;
        end
        if (iv2 && ir2) begin
            q2.push_back('{p: 32'(e2), acc: cyc + 1});
            nacc2 <= nacc2 + 1;
            if (last2 >= 0) check("u2_issue_interval", 32'(cyc + 1 - last2), 32'd3);
            last2 <= cyc + 1;
        end
        if (iv16 && ir16) begin
            q16.push_back('{p: e16, acc: cyc + 1});
            nacc16 <= nacc16 + 1;
        end
    end

    // Output side: latency on out_valid rise, product on handshake.
    always @(negedge clk) begin
        if (ov8 && !pv8) begin
            if (q8.size() == 0) fail_now("u8_spurious_output");
            else check("u8_latency", 32'(cyc - q8[0].acc), 32'd8);
        end
        if (ov8 && or8 && q8.size() > 0) begin
            check("u8_p", 32'(p8), q8[0].p);
            void'(q8.pop_front());
        end
        pv8 <= ov8;

        if (ov8b && !pv8b) begin
            if (q8b.size() == 0) fail_now("u8b_spurious_output");
            else check("u8b_latency", 32'(cyc - q8b[0].acc), 32'd4);
        end
        if (ov8b && or8b && q8b.size() > 0) begin
            check("u8b_p", 32'(p8b), q8b[0].p);
            void'(q8b.pop_front());
        end
        pv8b <= ov8b;

        if (ov2 && !pv2) begin
            if (q2.size() == 0) fail_now("u2_spurious_output");
            else check("u2_latency", 32'(cyc - q2[0].acc), 32'd1);
        end
        if (ov2 && or2 && q2.size() > 0) begin
            check("u2_p", 32'(p2), q2[0].p);
            void'(q2.pop_front());
        end
        pv2 <= ov2;

        if (ov16 && !pv16) begin
            if (q16.size() == 0) fail_now("u16_spurious_output");
            else check("u16_latency", 32'(cyc - q16[0].acc), 32'd4);
        end
        if (ov16 && or16 && q16.size() > 0) begin
            check("u16_p", p16, q16[0].p);
            void'(q16.pop_front());
        end
        pv16 <= ov16;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd16) or16 = 1'($urandom_range(0, 1));
            else       or16 = 1'b1;
        end
    end

    function automatic int nacc(input int id);
        case (id)
            0:       return nacc8;
            1:       return nacc8b;
            2:       return nacc2;
            default: return nacc16;
        endcase
    endfunction

    // Presents one operand pair and returns just after the accepting edge.
    task automatic send(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] e, input logic hold);
        int n0;
        int k;
        if (!hold) begin
            @(posedge clk);
            #1;
        end
        n0 = nacc(id);
        k  = 0;
        case (id)
            0:       begin a8  = a[7:0]; b8  = b[7:0]; e8  = e[15:0]; iv8  = 1'b1; end
            1:       begin a8b = a[7:0]; b8b = b[7:0]; e8b = e[15:0]; iv8b = 1'b1; end
            2:       begin a2  = a[1:0]; b2  = b[1:0]; e2  = e[3:0];  iv2  = 1'b1; end
            default: begin a16 = a;      b16 = b;      e16 = e;       iv16 = 1'b1; end
        endcase
        while (nacc(id) == n0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (k >= 300) fail_now("accept_timeout");
        if (!hold) begin
            // Scramble operands after acceptance; the result must not change.
            case (id)
                0:       begin iv8  = 1'b0; a8  = 8'($urandom);  b8  = 8'($urandom);  end
                1:       begin iv8b = 1'b0; a8b = 8'($urandom);  b8b = 8'($urandom);  end
                2:       begin iv2  = 1'b0; a2  = 2'($urandom);  b2  = 2'($urandom);  end
                default: begin iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); end
            endcase
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((q8.size() + q8b.size() + q2.size() + q16.size()) != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(ir8), 32'd1);
        check("reset_out_valid", 32'(ov8), 32'd0);
        check("reset_p", 32'(p8), 32'd0);
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_p16", p16, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0);
        drain();
        send(0, 16'h0000, 16'h00A5, 32'h0000_0000, 1'b0);
        send(0, 16'h0001, 16'h0080, 32'h0000_0080, 1'b0);
        drain();

        // Backpressure: hold DONE for 5 cycles while pulsing in_valid.
        or8 = 1'b0;
        send(0, 16'h000C, 16'h000A, 32'h0000_0078, 1'b0);
        k = 0;
        while (!ov8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) fail_now("bp_out_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            iv8 = (i == 2);
            a8  = 8'h33;
            b8  = 8'h33;
            e8  = 16'h0A29;
            @(negedge clk);
            check("bp_out_valid_held", 32'(ov8), 32'd1);
            check("bp_p_held", 32'(p8), 32'h0078);
            check("bp_in_ready_low", 32'(ir8), 32'd0);
        end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 32'(ir8), 32'd1);
        check("bp_release_out_valid", 32'(ov8), 32'd0);
        check("bp_release_p_kept", 32'(p8), 32'h0078);

        // Asynchronous reset while cnt==3.
        send(0, 16'h00FF, 16'h000F, 32'h0000_0EF1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("midop_busy", 32'(busy8), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_rst_out_valid", 32'(ov8), 32'd0);
        check("midop_rst_in_ready", 32'(ir8), 32'd1);
        check("midop_rst_p", 32'(p8), 32'd0);
        check("midop_rst_busy", 32'(busy8), 32'd0);
        q8.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(0, 16'd3, 16'd5, 32'd15, 1'b0);
        drain();

        send(1, 16'd13, 16'd11, 32'd143, 1'b0);
        send(1, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0);
        drain();

        // WIDTH=2 exhaustive, in_valid held high throughout.
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                send(2, 16'(x), 16'(y), 32'(x * y), 1'b1);
            end
        end
        iv2 = 1'b0;
        drain();

        rnd16 = 1'b1;
        send(3, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(3, ra, rb, 32'(ra) * 32'(rb), 1'b0);
        end
        drain();
        rnd16 = 1'b0;

        check("q8_empty", 32'(q8.size()), 32'd0);
        check("q16_empty", 32'(q16.size()), 32'd0);
        check("u2_accept_count", 32'(nacc2), 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
